// File: rtl/vga_pat_pkg.sv
// Shared colour constants, mode codes and the bar-index-to-colour table for the VGA test-pattern source.
package vga_pat_pkg;

    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] BLACK   = 16'h0000;

    localparam logic [1:0] MODE_SOLID  = 2'd0;
    localparam logic [1:0] MODE_BARS   = 2'd1;
    localparam logic [1:0] MODE_CHECK  = 2'd2;
    localparam logic [1:0] MODE_SCROLL = 2'd3;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pat_bar_lut.sv
// Combinational colour-bar lookup: x coordinate in, one of eight bar colours out.
// Anything at or beyond H_ACTIVE lands in the last (black) bar.
module vga_pat_bar_lut
    import vga_pat_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int H_ACTIVE = 640
) (
    input  logic [COORD_W-1:0] x_i,
    output logic [15:0]        color_o
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] idx;

    // Bar index is the number of bar boundaries at or below x; no divider needed.
    always_comb begin
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x_i >= COORD_W'(k * BAR_W)) begin
                idx = 3'(k);
            end
        end
        color_o = bar_color(idx);
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: solid, colour bars, checkerboard and scrolling bars, mode latched at frame start.
// Optional white one-pixel frame border enabled by defining VGA_PAT_BORDER_EN.
module vga_pattern_gen
    import vga_pat_pkg::*;
#(
    parameter int COORD_W     = 10,
    parameter int PIX_W       = 16,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int CHECK_LOG2  = 5,
    parameter int SCROLL_STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [1:0]         mode_sel,
    input  logic [PIX_W-1:0]   solid_color,
    output logic [PIX_W-1:0]   pix_data,
    output logic               frame_start,
    output logic [1:0]         mode_active,
    output logic [COORD_W-1:0] dbg_scroll_off,
    output logic [15:0]        dbg_frame_cnt
);

    localparam logic [COORD_W:0]   H_EXT    = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0]   STEP_EXT = (COORD_W+1)'(SCROLL_STEP);
    localparam logic [COORD_W-1:0] H_LIM    = COORD_W'(H_ACTIVE);
`ifdef VGA_PAT_BORDER_EN
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_ACTIVE - 1);
`endif

    logic [1:0]         mode_q, mode_d;
    logic [COORD_W-1:0] scroll_q, scroll_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic               fs_q, fs_d;

    logic               blank;
    logic               fs;
    logic [COORD_W:0]   scroll_sum;
    logic [COORD_W-1:0] scroll_next;
    logic [COORD_W:0]   xs_sum;
    logic [COORD_W-1:0] xs;
    logic [COORD_W-1:0] lut_x;
    logic [15:0]        bar_rgb;

    assign blank = (&pix_x) | (&pix_y);
    assign fs    = (pix_x == '0) && (pix_y == '0);

    // Offset and mode take their next values on the fs cycle itself, so pixel (0,0) already uses them.
    always_comb begin
        scroll_sum  = {1'b0, scroll_q} + STEP_EXT;
        scroll_next = (scroll_sum >= H_EXT) ? COORD_W'(scroll_sum - H_EXT)
                                            : scroll_sum[COORD_W-1:0];
        scroll_d    = fs ? scroll_next : scroll_q;
        mode_d      = fs ? mode_sel : mode_q;
        frame_cnt_d = fs ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // Both operands are below H_ACTIVE for on-screen x, so one conditional subtract wraps.
    always_comb begin
        xs_sum = {1'b0, pix_x} + {1'b0, scroll_d};
        xs     = (xs_sum >= H_EXT) ? COORD_W'(xs_sum - H_EXT) : xs_sum[COORD_W-1:0];
        lut_x  = pix_x;
        if (mode_d == MODE_SCROLL) begin
            lut_x = (pix_x < H_LIM) ? xs : H_LIM;
        end
    end

    vga_pat_bar_lut #(
        .COORD_W  (COORD_W),
        .H_ACTIVE (H_ACTIVE)
    ) u_bar_lut (
        .x_i     (lut_x),
        .color_o (bar_rgb)
    );

    always_comb begin
        pix_d = '0;
        fs_d  = fs;
        if (!blank) begin
            case (mode_d)
                MODE_SOLID: pix_d = solid_color;
                MODE_CHECK: pix_d = (pix_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2]) ? PIX_W'(WHITE)
                                                                           : PIX_W'(BLACK);
                default:    pix_d = PIX_W'(bar_rgb);
            endcase
`ifdef VGA_PAT_BORDER_EN
            if ((pix_x == '0) || (pix_x == X_LAST) || (pix_y == '0) || (pix_y == Y_LAST)) begin
                pix_d = PIX_W'(WHITE);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_SOLID;
            scroll_q    <= '0;
            frame_cnt_q <= '0;
            pix_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            scroll_q    <= scroll_d;
            frame_cnt_q <= frame_cnt_d;
            pix_q       <= pix_d;
            fs_q        <= fs_d;
        end
    end

    assign pix_data       = pix_q;
    assign frame_start    = fs_q;
    assign mode_active    = mode_q;
    assign dbg_scroll_off = scroll_q;
    assign dbg_frame_cnt  = frame_cnt_q;

endmodule
